// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter types, constants and parity helper
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - power-of-two depth byte buffer feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // full/empty come from the registered count, so a same-edge pop never frees a slot early
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       wr_i,
    output logic       full_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e state;
    uart_state_e state_next;
    logic [15:0] timer;
    logic        timer_done;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tx_q;
    logic        tx_next;
    logic        load;
    logic        bit_entry;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_i),
        .pop   (load),
        .din   (data_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (full_o)
    );

    assign timer_done = (timer == '0);
    // A frame begins only from IDLE or straight out of STOP; that is when a byte is popped.
    assign load       = (state_next == ST_START) && (state != ST_START);
    assign bit_entry  = (state_next != state) || ((state == ST_DATA) && timer_done);
    assign tx_o       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_START;
            end
            ST_START: begin
                if (timer_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (timer_done && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
            ST_PARITY: begin
                if (timer_done) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (timer_done) state_next = fifo_empty ? ST_IDLE : ST_START;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_next = UART_IDLE_LEVEL;
        busy_o  = (state != ST_IDLE) || !fifo_empty;
        unique case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = par_q;
`endif
            default:   tx_next = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            tx_q <= tx_next;
            if (bit_entry) begin
                timer <= DIV_M1;
            end else if (!timer_done) begin
                timer <= timer - 16'd1;
            end
            if (load) begin
                shreg   <= fifo_dout;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                par_q   <= even_parity(fifo_dout);
`endif
            end else if ((state == ST_DATA) && timer_done) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (CLK_DIV=4, FIFO_DEPTH=4)
module tb_uart_tx;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL        = FB * CD;
    localparam int TRACE_LEN = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_i;
    logic [7:0] data_i;
    logic       full_o;
    logic       busy_o;
    logic       tx_o;

    int   cyc = 0;
    logic trace [TRACE_LEN];
    int   n_assert = 0;
    int   n_fail   = 0;

    uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .wr_i   (wr_i),
        .full_o (full_o),
        .busy_o (busy_o),
        .tx_o   (tx_o)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; trace[k] is tx_o between edge k and k+1
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < TRACE_LEN) trace[cyc] = tx_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic int find_start(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (trace[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic check_frame(input int s, input logic [7:0] d, input string tag);
        logic          e;
        logic [CD-1:0] o;
        for (int b = 0; b < FB; b++) begin
            if (b == 0)                    e = 1'b0;
            else if (b <= 8)               e = d[b-1];
            else if (b == 9 && FB == 11)   e = ^d;
            else                           e = 1'b1;
            for (int k = 0; k < CD; k++) o[k] = trace[s + b*CD + k];
            check($sformatf("%s_slot%0d", tag, b), 32'(o), 32'({CD{e}}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n0;
        int         r;
        int         t;
        logic [7:0] v3 [3];
        v3 = '{8'h00, 8'hFF, 8'h55};

        // reset with a write strobe held high; the write must be ignored
        rst = 1'b1; wr_i = 1'b1; data_i = 8'h99;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_full", full_o, 0);
        rst = 1'b0; wr_i = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_tx", tx_o, 1);

        // single byte 0xA5: start bit appears exactly two edges after the write
        n0 = cyc + 1; data_i = 8'hA5; wr_i = 1'b1;
        @(negedge clk); wr_i = 1'b0;
        check("a5_busy", busy_o, 1);
        wait_cyc(n0 + 2 + FL + 2);
        check("a5_pre_start", trace[n0+1], 1);
        check("a5_start_pos", find_start(n0, n0 + 2 + FL), n0 + 2);
        check_frame(n0 + 2, 8'hA5, "a5");
        check("a5_idle_after", trace[n0+2+FL], 1);
        check("a5_busy_after", busy_o, 0);

        // three consecutive writes: frames must be contiguous
        n0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            data_i = v3[i]; wr_i = 1'b1;
            @(negedge clk);
        end
        wr_i = 1'b0;
        wait_cyc(n0 + 2 + 3*FL + 2);
        for (int k = 0; k < 3; k++) check_frame(n0 + 2 + k*FL, v3[k], $sformatf("b2b%0d", k));
        check("b2b_busy_after", busy_o, 0);

        // six consecutive writes: full after the fifth accepted, sixth dropped
        n0 = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            data_i = 8'h31 + 8'(i); wr_i = 1'b1;
            @(negedge clk);
            check($sformatf("fill_full%0d", i), full_o, (i >= 4) ? 1 : 0);
        end
        wr_i = 1'b0;
        wait_cyc(n0 + 2 + 6*FL + 2);
        for (int k = 0; k < 5; k++) check_frame(n0 + 2 + k*FL, 8'h31 + 8'(k), $sformatf("fill%0d", k));
        check("fill_no_sixth", find_start(n0 + 2 + 5*FL, n0 + 2 + 6*FL), -1);
        check("fill_busy_after", busy_o, 0);

        // write held across the pop edge while full must be rejected
        n0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            data_i = 8'h41 + 8'(i); wr_i = 1'b1;
            @(negedge clk);
        end
        check("pop_full_before", full_o, 1);
        data_i = 8'hEE; t = 0;
        while (full_o && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("pop_edge", cyc, n0 + 1 + FL);
        check("pop_full_after", full_o, 0);
        data_i = 8'h46;
        @(negedge clk); wr_i = 1'b0;
        check("pop_refill_full", full_o, 1);
        wait_cyc(n0 + 2 + 6*FL + 2);
        for (int k = 0; k < 6; k++) check_frame(n0 + 2 + k*FL, 8'h41 + 8'(k), $sformatf("pop%0d", k));
        check("pop_no_extra", find_start(n0 + 2 + 6*FL, cyc - 1), -1);

        // reset during data bit 3 of 0x3C aborts the frame
        n0 = cyc + 1; data_i = 8'h3C; wr_i = 1'b1;
        @(negedge clk); wr_i = 1'b0;
        wait_cyc(n0 + 19);
        check("abort_bit3_tx", tx_o, 1);
        check("abort_bit3_busy", busy_o, 1);
        check("abort_bit2", trace[n0 + 2 + 3*CD], 1);
        rst = 1'b1; wr_i = 1'b1; data_i = 8'h99;
        @(negedge clk);
        rst = 1'b0; wr_i = 1'b0;
        check("abort_tx", tx_o, 1);
        check("abort_busy", busy_o, 0);
        check("abort_full", full_o, 0);
        r = cyc;
        wait_cyc(r + 2*FL);
        check("abort_no_frame", find_start(r, cyc - 1), -1);
        check("abort_busy_later", busy_o, 0);

        // 0x07: frame length visible through busy_o falling edge
        n0 = cyc + 1; data_i = 8'h07; wr_i = 1'b1;
        @(negedge clk); wr_i = 1'b0;
        wait_cyc(n0 + FL);
        check("p07_busy_last", busy_o, 1);
        @(negedge clk);
        check("p07_busy_end", busy_o, 0);
        wait_cyc(n0 + 2 + FL + 2);
        check_frame(n0 + 2, 8'h07, "p07");
        check("p07_idle_after", trace[n0+2+FL], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
